// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller in front of a single-port sync_ram.
// Optional almost_full output when RAM_FIFO_WATERMARK_EN is defined.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   wr_valid/ready/data push handshake
//   rd_valid/ready/data pop handshake, registered head
//   count, full, empty  occupancy status
//   ram_en/we/addr/din  drive to sync_ram
//   ram_dout            sync_ram read data, one cycle after strobe
//   almost_full         (RAM_FIFO_WATERMARK_EN only) count >= AFULL_THRESH
module ram_fifo_ctrl #(
   parameter int DATA_W       = 8,
   parameter int ADDR_W       = 4,
   parameter int AFULL_THRESH = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
`ifdef RAM_FIFO_WATERMARK_EN
   ,
   output logic              almost_full
`endif
);

   localparam logic [ADDR_W:0] DEPTH_C =
      (ADDR_W+1)'(1 << ADDR_W);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   mem_cnt_q, mem_cnt_d;
   logic              rd_pend_q, rd_pend_d;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] din_q;
   logic [ADDR_W:0]   count_d;

   logic pop;
   logic do_read;
   logic do_write;
   logic full_w;

   assign pop      = rd_valid_q & rd_ready;
   // Prefetch only when the output slot is free or
   // being freed this cycle; one read in flight max.
   assign do_read  = (mem_cnt_q != '0) & ~rd_pend_q
                   & (~rd_valid_q | pop);
   assign full_w   = (mem_cnt_q == DEPTH_C);
   // Reads win the single RAM port.
   assign wr_ready = ~full_w & ~do_read;
   assign do_write = wr_valid & wr_ready;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      mem_cnt_d  = mem_cnt_q;
      rd_valid_d = rd_valid_q;
      rd_data_d  = rd_data_q;
      rd_pend_d  = do_read;
      if (do_write) begin
         wr_ptr_d  = wr_ptr_q + 1'b1;
         mem_cnt_d = mem_cnt_q + 1'b1;
      end
      if (do_read) begin
         rd_ptr_d  = rd_ptr_q + 1'b1;
         mem_cnt_d = mem_cnt_q - 1'b1;
      end
      if (rd_pend_q) begin
         rd_valid_d = 1'b1;
         rd_data_d  = ram_dout;
      end else if (pop) begin
         rd_valid_d = 1'b0;
      end
      count_d = mem_cnt_d
              + {{ADDR_W{1'b0}}, rd_pend_d}
              + {{ADDR_W{1'b0}}, rd_valid_d};
   end

   // RAM strobes are gated by rst_n so nothing is
   // written while reset is held.
   always_comb begin
      ram_en   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = addr_q;
      ram_din  = din_q;
      if (do_read) begin
         ram_en   = rst_n;
         ram_addr = rd_ptr_q;
      end else if (do_write) begin
         ram_en   = rst_n;
         ram_we   = rst_n;
         ram_addr = wr_ptr_q;
         ram_din  = wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         mem_cnt_q  <= '0;
         rd_pend_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         addr_q     <= '0;
         din_q      <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         mem_cnt_q  <= mem_cnt_d;
         rd_pend_q  <= rd_pend_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         addr_q     <= ram_addr;
         din_q      <= ram_din;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign full     = full_w;
   assign count    = mem_cnt_q
                   + {{ADDR_W{1'b0}}, rd_pend_q}
                   + {{ADDR_W{1'b0}}, rd_valid_q};
   assign empty    = (count == '0);

`ifdef RAM_FIFO_WATERMARK_EN
   localparam logic [ADDR_W:0] AF_C =
      (ADDR_W+1)'(AFULL_THRESH);
   logic af_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) af_q <= 1'b0;
      else        af_q <= (count_d >= AF_C);
   end

   assign almost_full = af_q;
`else
   logic unused_cnt;
   assign unused_cnt = ^count_d;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed bench for ram_fifo_ctrl
// with a behavioural single-port RAM attached.
module tb_ram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [7:0] wr_data = '0;
   logic       rd_valid;
   logic       rd_ready = 1'b0;
   logic [7:0] rd_data;
   logic [4:0] count;
   logic       full;
   logic       empty;
   logic       ram_en;
   logic       ram_we;
   logic [3:0] ram_addr;
   logic [7:0] ram_din;
   logic [7:0] ram_dout = '0;
`ifdef RAM_FIFO_WATERMARK_EN
   logic       almost_full;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [16];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_din;
         else        ram_dout <= mem[ram_addr];
      end
   end

   ram_fifo_ctrl #(
      .DATA_W(8), .ADDR_W(4), .AFULL_THRESH(12)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_data(rd_data),
      .count(count), .full(full), .empty(empty),
      .ram_en(ram_en), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout)
`ifdef RAM_FIFO_WATERMARK_EN
      ,
      .almost_full(almost_full)
`endif
   );

   task automatic do_reset();
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      wr_data  = '0;
      rst_n    = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic push(input logic [7:0] d,
                       output logic [3:0] a,
                       output logic we,
                       output bit ok);
      ok = 1'b0;
      a  = '0;
      we = 1'b0;
      wr_valid = 1'b1;
      wr_data  = d;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (wr_ready) begin
            ok = 1'b1;
            a  = ram_addr;
            we = ram_we;
         end
         @(posedge clk);
         #1;
      end
      wr_valid = 1'b0;
   endtask

   task automatic pop(output logic [7:0] d,
                      output bit ok);
      ok = 1'b0;
      d  = '0;
      rd_ready = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (rd_valid) begin
            ok = 1'b1;
            d  = rd_data;
         end
         @(posedge clk);
         #1;
      end
      rd_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0 || count !== 5'd0 ||
          empty !== 1'b1 || full !== 1'b0 ||
          ram_en !== 1'b0 || rd_data !== 8'h00) begin
         errors++;
         $display("FAIL reset: rv=%b cnt=%0d e=%b f=%b en=%b d=%h",
                  rd_valid, count, empty, full, ram_en,
                  rd_data);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_wr_ready: got %b want 1",
                  wr_ready);
      end
   endtask

   task automatic test_basic();
      logic [7:0] vals [3];
      logic [3:0] a;
      logic we;
      logic [7:0] d;
      bit ok;
      vals[0] = 8'hA5;
      vals[1] = 8'h3C;
      vals[2] = 8'h7F;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         push(vals[i], a, we, ok);
         checks++;
         if (!ok || a !== 4'(i) || we !== 1'b1) begin
            errors++;
            $display("FAIL basic_push%0d: ok=%b addr=%0d we=%b want addr=%0d we=1",
                     i, ok, a, we, i);
         end
      end
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'hA5 ||
          count !== 5'd3) begin
         errors++;
         $display("FAIL basic_head: rv=%b d=%h cnt=%0d want 1 A5 3",
                  rd_valid, rd_data, count);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         pop(d, ok);
         checks++;
         if (!ok || d !== vals[i]) begin
            errors++;
            $display("FAIL basic_pop%0d: ok=%b got %h want %h",
                     i, ok, d, vals[i]);
         end
      end
      @(negedge clk);
      checks++;
      if (empty !== 1'b1 || count !== 5'd0) begin
         errors++;
         $display("FAIL basic_empty: e=%b cnt=%0d want 1 0",
                  empty, count);
      end
   endtask

   task automatic test_full();
      logic [3:0] a;
      logic we;
      logic [7:0] d;
      bit ok;
      bit stalled;
      do_reset();
      for (int i = 0; i < 17; i++) begin
         push(8'(i), a, we, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL full_push%0d: got timeout want accepted",
                     i);
         end
         if (i == 15) begin
            @(negedge clk);
            checks++;
            if (count !== 5'd16 || rd_valid !== 1'b1 ||
                rd_data !== 8'h00 || full !== 1'b0) begin
               errors++;
               $display("FAIL full_mid: cnt=%0d rv=%b d=%h f=%b want 16 1 00 0",
                        count, rd_valid, rd_data, full);
            end
            @(posedge clk);
            #1;
         end
      end
      @(negedge clk);
      checks++;
      if (count !== 5'd17 || full !== 1'b1 ||
          wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_top: cnt=%0d f=%b wr_rdy=%b want 17 1 0",
                  count, full, wr_ready);
      end
      @(posedge clk);
      #1;
      wr_valid = 1'b1;
      wr_data  = 8'h11;
      stalled  = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (wr_ready) stalled = 1'b0;
      end
      checks++;
      if (!stalled || count !== 5'd17) begin
         errors++;
         $display("FAIL full_stall: stalled=%b cnt=%0d want 1 17",
                  stalled, count);
      end
      @(posedge clk);
      #1 rd_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h00 ||
          wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_pop: rv=%b d=%h wr_rdy=%b want 1 00 0",
                  rd_valid, rd_data, wr_ready);
      end
      @(posedge clk);
      #1 rd_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL full_resume: wr_rdy=%b want 1",
                  wr_ready);
      end
      @(posedge clk);
      #1 wr_valid = 1'b0;
      for (int i = 1; i < 18; i++) begin
         pop(d, ok);
         checks++;
         if (!ok || d !== 8'(i)) begin
            errors++;
            $display("FAIL full_drain%0d: ok=%b got %h want %h",
                     i, ok, d, 8'(i));
         end
      end
      @(negedge clk);
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL full_empty: e=%b want 1", empty);
      end
   endtask

   task automatic test_wrap();
      logic [3:0] a;
      logic we;
      logic [7:0] d;
      bit ok;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         push(8'(i), a, we, ok);
         checks++;
         if (!ok || a !== 4'(i % 16) || we !== 1'b1) begin
            errors++;
            $display("FAIL wrap_push%0d: ok=%b addr=%0d want %0d",
                     i, ok, a, i % 16);
         end
         pop(d, ok);
         checks++;
         if (!ok || d !== 8'(i)) begin
            errors++;
            $display("FAIL wrap_pop%0d: ok=%b got %h want %h",
                     i, ok, d, 8'(i));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_d;
      logic rd_now, prev_rd, acc;
      int popped;
      do_reset();
      exp_d   = '0;
      prev_rd = 1'b0;
      popped  = 0;
      wr_data = '0;
      wr_valid = 1'b1;
      rd_ready = 1'b1;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         rd_now = ram_en & ~ram_we;
         checks++;
         if (rd_now && prev_rd) begin
            errors++;
            $display("FAIL b2b_reads cyc%0d: got back-to-back reads want gap",
                     c);
         end
         prev_rd = rd_now;
         acc = wr_ready;
         if (rd_valid) begin
            checks++;
            if (rd_data !== exp_d) begin
               errors++;
               $display("FAIL b2b_order: got %h want %h",
                        rd_data, exp_d);
            end
            exp_d = exp_d + 8'd1;
            popped++;
         end
         @(posedge clk);
         #1;
         if (acc) wr_data = wr_data + 8'd1;
      end
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      checks++;
      if (popped < 20) begin
         errors++;
         $display("FAIL b2b_rate: got %0d pops want >= 20",
                  popped);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      wr_valid = 1'b1;
      wr_data  = 8'h5A;
      @(posedge clk);
      #1 wr_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (ram_en !== 1'b1 || ram_we !== 1'b0) begin
         errors++;
         $display("FAIL rmid_strobe: en=%b we=%b want 1 0",
                  ram_en, ram_we);
      end
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (rd_valid !== 1'b0 || count !== 5'd0 ||
          empty !== 1'b1 || ram_en !== 1'b0) begin
         errors++;
         $display("FAIL rmid_clear: rv=%b cnt=%0d e=%b en=%b want 0 0 1 0",
                  rd_valid, count, empty, ram_en);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0 || count !== 5'd0 ||
          empty !== 1'b1) begin
         errors++;
         $display("FAIL rmid_after: rv=%b cnt=%0d e=%b want 0 0 1",
                  rd_valid, count, empty);
      end
   endtask

`ifdef RAM_FIFO_WATERMARK_EN
   task automatic test_watermark();
      logic [3:0] a;
      logic we;
      logic [7:0] d;
      bit ok;
      do_reset();
      for (int i = 0; i < 11; i++) push(8'(i), a, we, ok);
      @(negedge clk);
      checks++;
      if (count !== 5'd11 || almost_full !== 1'b0) begin
         errors++;
         $display("FAIL wm_11: cnt=%0d af=%b want 11 0",
                  count, almost_full);
      end
      @(posedge clk);
      #1;
      push(8'd11, a, we, ok);
      @(negedge clk);
      checks++;
      if (count !== 5'd12 || almost_full !== 1'b1) begin
         errors++;
         $display("FAIL wm_12: cnt=%0d af=%b want 12 1",
                  count, almost_full);
      end
      @(posedge clk);
      #1;
      pop(d, ok);
      @(negedge clk);
      checks++;
      if (count !== 5'd11 || almost_full !== 1'b0) begin
         errors++;
         $display("FAIL wm_fall: cnt=%0d af=%b want 11 0",
                  count, almost_full);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
`ifdef RAM_FIFO_WATERMARK_EN
      test_watermark();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
